instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Producer-side counterpart to the opcode decoder in the single-cycle MIPS core.
- Takes decoded instruction fields over a valid/ready stream and encodes them into 32-bit MIPS R/I/J words.
- Writes the words sequentially into instruction memory, so programs load from field-level stimulus rather than hand-packed hex.
- Sits between the testbench/host and the instruction-memory write port; idle once the core runs.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words; must be <= 2**ADDR_WIDTH.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock domain, reset is asynchronous and active-low.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader can accept a bundle.
- fmt  input  2  format of the bundle: 0=R, 1=I, 2=J, 3=illegal.
- opcode  input  6  instr[31:26].
- rs  input  5  R/I source register.
- rt  input  5  R/I target register.
- rd  input  5  R destination register.
- shamt  input  5  R shift amount.
- funct  input  6  R function code.
- imm  input  16  I immediate.
- target  input  26  J target.
- last  input  1  bundle is the final instruction of the session.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD.
- done  output  1  level, high in DONE.
- err  output  1  level, high in ERR.
- count  output  ADDR_WIDTH+1  words written this session.

Behaviour:
- States: IDLE, LOAD, DONE, ERR.
- Reset (asynchronous, takes effect immediately): state=IDLE.
  - Cleared outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, count=0.
  - Reset mid-session abandons the session. No partial write completes after rst_n falls.
- IDLE, DONE, ERR + start: go to LOAD, set write pointer to BASE_ADDR, clear count, done and err.
- In LOAD, start is ignored.
- in_ready = (state==LOAD). It is combinational from state; no dependence on in_valid.
- Accept occurs when in_valid && in_ready at a rising edge. Fields are sampled at that edge.
- Encoding:
  - R: {opcode,rs,rt,rd,shamt,funct}.
  - I: {opcode,rs,rt,imm}.
  - J: {opcode,target}.
  - Unused fields are ignored.
- Latency: mem_we, mem_addr and mem_wdata are registered. mem_we is high in exactly the cycle after the accept.
- mem_addr equals the write pointer at accept. The pointer then increments by 1 and count increments by 1 in that same edge.
- Back-to-back accepts on consecutive cycles produce consecutive mem_we cycles. Sustained throughput is one word per clock.
- Legality checks, evaluated at accept:
  - fmt==3 is illegal.
  - fmt==R with opcode!=0 is illegal.
  - An illegal bundle is not written (mem_we stays 0). State goes to ERR and count is unchanged.
- Accept with last=1: the word is written, then the state goes to DONE.
- Capacity:
  - If the accepted word lands at offset DEPTH-1 (count becomes DEPTH) and last=0, the word is written, then the state goes to ERR.
  - No pointer wrap-around ever occurs.
  - last=1 on that word wins and the state goes to DONE.
- done and err are registered. Each rises the cycle after the terminating accept and holds until the next start or reset.
- busy falls in the same cycle that done or err rises.
- count holds its final value in DONE and ERR.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
- Reset then start; accept R {rs=1,rt=2,rd=3,shamt=0,funct=0x20} with last=0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
- Back-to-back accepts of I lw {op=35,rs=0,rt=8,imm=4}, then I beq {op=4,rs=8,rt=9,imm=0xFFFF}, then J {op=2,target=0x0000010} with last=1 -> three consecutive mem_we cycles:
  - addr 0: 0x8C080004.
  - addr 1: 0x1109FFFF.
  - addr 2: 0x08000010.
  - Afterwards done=1, count=3, busy=0.
- Illegal bundles -> no mem_we, err=1 the cycle after accept, count unchanged:
  - fmt=3.
  - fmt=R with opcode=15.
  - start then recovers to LOAD with err=0.
- DEPTH=4, BASE_ADDR=0: four accepts with last=0 -> writes at 0..3, then err=1, count=4, in_ready=0, no fifth write. Repeat with last=1 on the fourth accept -> done=1, err=0.
- rst_n asserted low mid-session between accept and write cycle -> mem_we stays 0 and all outputs are at reset values immediately. After release, start writes from BASE_ADDR again.
- in_valid held low in LOAD for 5 cycles, then start pulsed during LOAD -> no writes, pointer unchanged, start ignored, busy stays 1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: encodes decoded MIPS field bundles into R/I/J words and
// writes them sequentially into instruction memory.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start           - one-cycle pulse that opens a load session (ignored in LOAD)
//   in_valid        - field bundle valid
//   in_ready        - high while loading; combinational from state only
//   fmt             - bundle format: 0=R, 1=I, 2=J, 3=illegal
//   opcode .. last  - instruction fields; last marks the final word of a session
//   mem_we          - one-cycle write strobe, the cycle after an accept
//   mem_addr        - word address of the write (holds when mem_we=0)
//   mem_wdata       - encoded instruction word (holds when mem_we=0)
//   busy/done/err   - registered state levels for LOAD/DONE/ERR
//   count           - words written in the current session
module instr_mem_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    input  logic                  last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [1:0]          FMT_R   = 2'd0;
    localparam logic [1:0]          FMT_I   = 2'd1;
    localparam logic [1:0]          FMT_ILL = 2'd3;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  illegal;
    logic [31:0]           word;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // R-type words must carry opcode 0 (SPECIAL); anything else cannot be decoded back.
    assign illegal   = (fmt == FMT_ILL) || ((fmt == FMT_R) && (opcode != 6'd0));
    assign word      = (fmt == FMT_R) ? {opcode, rs, rt, rd, shamt, funct} :
                       (fmt == FMT_I) ? {opcode, rs, rt, imm} :
                                        {opcode, target};
    assign count_inc = count_q + (ADDR_WIDTH+1)'(1);
    // The write pointer is BASE_ADDR plus words written; the session stops at DEPTH
    // words, so the pointer never wraps.
    assign wr_addr   = BASE_ADDR + count_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q != LOAD) begin
            if (start) begin
                state_d = LOAD;
                count_d = '0;
            end
        end else if (in_valid) begin
            if (illegal) begin
                state_d = ERR;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = word;
                count_d     = count_inc;
                // last wins over the capacity limit on the final slot
                state_d     = last ? DONE : (count_inc == DEPTH_C) ? ERR : LOAD;
            end
        end
        busy_d = (state_d == LOAD);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: two loader instances (small depth / offset base) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  fmt = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        last = 1'b0;

    logic        in_ready_w [2];
    logic        mem_we_w   [2];
    logic [7:0]  mem_addr_w [2];
    logic [31:0] mem_wdata_w[2];
    logic        busy_w     [2];
    logic        done_w     [2];
    logic        err_w      [2];
    logic [8:0]  count_w    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_WIDTH(8), .DEPTH(4), .BASE_ADDR(8'd0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .last(last), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .count(count_w[0]));

    instr_mem_loader #(.ADDR_WIDTH(8), .DEPTH(6), .BASE_ADDR(8'd16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .last(last), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .count(count_w[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 loading, 2 finished, 3 error
    int          m_phase[2];
    int          m_cnt  [2];
    logic        m_we   [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_wdata[2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic int base_of(input int i);
        return (i == 0) ? 0 : 16;
    endfunction

    function automatic logic [31:0] encode();
        int unsigned w;
        if (fmt == 2'd0)
            w = opcode * 32'h0400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + shamt * 32'h40 + funct;
        else if (fmt == 2'd1)
            w = opcode * 32'h0400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
        else
            w = opcode * 32'h0400_0000 + target;
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_phase[i] = 0; m_cnt[i] = 0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
            end else begin
                m_we[i] = 1'b0;
                if (m_phase[i] != 1) begin
                    if (start) begin m_phase[i] = 1; m_cnt[i] = 0; end
                end else if (in_valid) begin
                    if (fmt == 2'd3 || (fmt == 2'd0 && opcode != 0)) begin
                        m_phase[i] = 3;
                    end else begin
                        m_we[i]    = 1'b1;
                        m_addr[i]  = 8'(base_of(i) + m_cnt[i]);
                        m_wdata[i] = encode();
                        m_cnt[i]   = m_cnt[i] + 1;
                        m_phase[i] = last ? 2 : (m_cnt[i] == depth_of(i)) ? 3 : 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d_in_ready", i), in_ready_w[i], m_phase[i] == 1);
                chk($sformatf("u%0d_busy", i), busy_w[i], m_phase[i] == 1);
                chk($sformatf("u%0d_done", i), done_w[i], m_phase[i] == 2);
                chk($sformatf("u%0d_err", i), err_w[i], m_phase[i] == 3);
                chk($sformatf("u%0d_count", i), count_w[i], m_cnt[i]);
                chk($sformatf("u%0d_mem_we", i), mem_we_w[i], m_we[i]);
                chk($sformatf("u%0d_mem_addr", i), mem_addr_w[i], m_addr[i]);
                chk($sformatf("u%0d_mem_wdata", i), mem_wdata_w[i], m_wdata[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] tg, input logic l);
        in_valid = 1'b1; fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = d;
        funct = fn; imm = im; target = tg; last = l;
        step();
        in_valid = 1'b0; last = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready_w[0], 0);
        chk({tag, "_mem_we"}, mem_we_w[0], 0);
        chk({tag, "_mem_addr"}, mem_addr_w[0], 0);
        chk({tag, "_mem_wdata"}, mem_wdata_w[0], 0);
        chk({tag, "_busy"}, busy_w[0], 0);
        chk({tag, "_done"}, done_w[0], 0);
        chk({tag, "_err"}, err_w[0], 0);
        chk({tag, "_count"}, count_w[0], 0);
    endtask

    initial begin
        repeat (2) step();
        chk_reset_vals("por");
        rst_n = 1'b1;
        step();

        // first R word
        pulse_start();
        chk("start_busy", busy_w[0], 1);
        send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0, 1'b0);
        chk("r_we", mem_we_w[0], 1);
        chk("r_addr", mem_addr_w[0], 0);
        chk("r_wdata", mem_wdata_w[0], 32'h0022_1820);
        chk("r_count", count_w[0], 1);
        chk("r_addr_base16", mem_addr_w[1], 16);

        // idle in LOAD, then start is ignored
        repeat (5) step();
        pulse_start();
        chk("idle_busy", busy_w[0], 1);
        chk("idle_count", count_w[0], 1);
        chk("idle_we", mem_we_w[0], 0);
        send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000_040, 1'b1);
        chk("close_addr", mem_addr_w[0], 1);
        chk("close_done", done_w[0], 1);

        // back-to-back program
        pulse_start();
        send(2'd1, 6'd35, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
        chk("lw_addr", mem_addr_w[0], 0);
        chk("lw_wdata", mem_wdata_w[0], 32'h8C08_0004);
        send(2'd1, 6'd4, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        chk("beq_we", mem_we_w[0], 1);
        chk("beq_addr", mem_addr_w[0], 1);
        chk("beq_wdata", mem_wdata_w[0], 32'h1109_FFFF);
        send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000_010, 1'b1);
        chk("j_we", mem_we_w[0], 1);
        chk("j_addr", mem_addr_w[0], 2);
        chk("j_wdata", mem_wdata_w[0], 32'h0800_0010);
        chk("prog_done", done_w[0], 1);
        chk("prog_count", count_w[0], 3);
        chk("prog_busy", busy_w[0], 0);

        // illegal bundles
        pulse_start();
        send(2'd3, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        chk("ill3_err", err_w[0], 1);
        chk("ill3_we", mem_we_w[0], 0);
        chk("ill3_count", count_w[0], 0);
        pulse_start();
        chk("recover_err", err_w[0], 0);
        chk("recover_busy", busy_w[0], 1);
        send(2'd0, 6'd15, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        chk("illr_err", err_w[0], 1);
        chk("illr_we", mem_we_w[0], 0);

        // capacity on u0 (DEPTH=4)
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send(2'd0, 6'd0, 5'(k), 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0);
            chk("cap_addr", mem_addr_w[0], k);
        end
        chk("cap_err", err_w[0], 1);
        chk("cap_count", count_w[0], 4);
        chk("cap_ready", in_ready_w[0], 0);
        send(2'd0, 6'd0, 5'd7, 5'd7, 5'd7, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0);
        chk("cap_no5th", mem_we_w[0], 0);
        pulse_start();
        for (int k = 0; k < 4; k++)
            send(2'd1, 6'd8, 5'd1, 5'(k), 5'd0, 5'd0, 6'd0, 16'(k), 26'd0, k == 3);
        chk("cap_last_done", done_w[0], 1);
        chk("cap_last_err", err_w[0], 0);

        // reset right after an accept edge
        pulse_start();
        send(2'd1, 6'd9, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h55, 26'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        rst_n = 1'b1;
        pulse_start();
        send(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3ff_ffff, 1'b0);
        chk("post_rst_addr", mem_addr_w[0], 0);
        chk("post_rst_we", mem_we_w[0], 1);

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 2000; n++) begin
            start    = ($urandom_range(0, 7) == 0);
            in_valid = 1'($urandom_range(0, 1));
            fmt      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            opcode   = ($urandom_range(0, 7) == 0 || fmt != 2'd0) ? 6'($urandom) : 6'd0;
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
            funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
            last = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
